instr_decode: RTL and testbench

//  Decode stage of the pipelined RISC core; the producing end of the function-unit control interface.

---
 rtl/instr_decode_if.sv | 39 +++
 rtl/instr_decode.sv | 204 ++++++++++++++++++++
 tb/tb_instr_decode.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_if.sv
// Control interface between the IF/DE register, the decode stage and the EX stage.
// master: the decode stage (consumes instr/in_valid/flush/out_ready, drives the control word).
// slave : the surrounding pipeline (drives instr/in_valid/flush/out_ready, reads the word).
//   in_valid/in_ready/instr : instruction handshake from IF/DE.
//   flush                   : branch taken in EX, kills held and incoming instruction.
//   out_valid/out_ready     : control-word handshake towards EX.
//   fs..illegal             : registered control word.
interface instr_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fs;
    logic [4:0]  sh;
    logic [4:0]  da;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [31:0] imm;
    logic        ma;
    logic        mb;
    logic        rw;
    logic        mw;
    logic [1:0]  md;
    logic [1:0]  bs;
    logic        ps;
    logic        illegal;

    modport master (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, fs, sh, da, sa, sb, imm, ma, mb, rw, mw, md, bs, ps, illegal
    );

    modport slave (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, fs, sh, da, sa, sb, imm, ma, mb, rw, mw, md, bs, ps, illegal
    );
endinterface

// File: rtl/instr_decode.sv
// Decode stage: turns a 32-bit instruction into a registered control word for the register
// file / EX stage, with valid/ready flow control, flush, illegal-opcode flagging and
// load-use bubble insertion.
// Ports:
//   clk   : rising-edge clock.
//   rst_n : synchronous active-low reset.
//   bus   : instr_decode_if.master (instruction in, control word out, flush).
// Instruction layout: op[31:25] DA[24:20] SA[19:15] SB[14:10] imm[14:0] SH[4:0].
module instr_decode #(
    parameter int unsigned IMM_W = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_decode_if.master bus
);

    typedef struct packed {
        logic [3:0]  fs;
        logic [4:0]  sh;
        logic [4:0]  da;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [31:0] imm;
        logic        ma;
        logic        mb;
        logic        rw;
        logic        mw;
        logic [1:0]  md;
        logic [1:0]  bs;
        logic        ps;
        logic        illegal;
    } ctrl_t;

    localparam logic [6:0] OpNop = 7'b0000000;
    localparam logic [6:0] OpMov = 7'b1000000;
    localparam logic [6:0] OpAdd = 7'b0000010;
    localparam logic [6:0] OpSub = 7'b0000101;
    localparam logic [6:0] OpSlt = 7'b1100101;
    localparam logic [6:0] OpAnd = 7'b0001000;
    localparam logic [6:0] OpOr  = 7'b0001001;
    localparam logic [6:0] OpXor = 7'b0001010;
    localparam logic [6:0] OpNot = 7'b0101110;
    localparam logic [6:0] OpLsl = 7'b0110000;
    localparam logic [6:0] OpLsr = 7'b0110001;
    localparam logic [6:0] OpLd  = 7'b0100001;
    localparam logic [6:0] OpSt  = 7'b0000001;
    localparam logic [6:0] OpAdi = 7'b0100010;
    localparam logic [6:0] OpSbi = 7'b0100101;
    localparam logic [6:0] OpAni = 7'b0101000;
    localparam logic [6:0] OpOri = 7'b0101001;
    localparam logic [6:0] OpXri = 7'b0101010;
    localparam logic [6:0] OpAiu = 7'b1100010;
    localparam logic [6:0] OpSiu = 7'b1000101;
    localparam logic [6:0] OpBz  = 7'b0100000;
    localparam logic [6:0] OpBnz = 7'b1100000;
    localparam logic [6:0] OpJmr = 7'b1100001;
    localparam logic [6:0] OpJmp = 7'b1000100;
    localparam logic [6:0] OpJml = 7'b0000111;

    localparam logic [1:0] MdMem = 2'b01;
    localparam logic [1:0] MdSlt = 2'b10;
    localparam logic [1:0] BsZ   = 2'b01;
    localparam logic [1:0] BsJr  = 2'b10;
    localparam logic [1:0] BsJi  = 2'b11;

    ctrl_t       ctrl_q, ctrl_d;
    logic        out_valid_q, out_valid_d;
    // Low during reset and for the first edge after it; holds in_ready off until then.
    logic        rdy_en_q;

    ctrl_t       dec;
    logic        legal;
    logic        sext;
    logic        zext;
    logic [6:0]  op;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        held_ld;
    logic        hazard;
    logic        bubble;
    logic        in_ready;
    logic        accept;

    assign op       = bus.instr[31:25];
    assign imm_sext = {{(32 - IMM_W){bus.instr[IMM_W-1]}}, bus.instr[IMM_W-1:0]};
    assign imm_zext = {{(32 - IMM_W){1'b0}}, bus.instr[IMM_W-1:0]};

    // Opcode decode. Immediate is only populated for ops that route it onto the B bus.
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        sext  = 1'b0;
        zext  = 1'b0;
        case (op)
            OpNop: ;
            OpMov: dec.rw = 1'b1;
            OpAdd: begin dec.fs = 4'b0010; dec.rw = 1'b1; end
            OpSub: begin dec.fs = 4'b0101; dec.rw = 1'b1; end
            OpSlt: begin dec.fs = 4'b0101; dec.rw = 1'b1; dec.md = MdSlt; end
            OpAnd: begin dec.fs = 4'b1000; dec.rw = 1'b1; end
            OpOr:  begin dec.fs = 4'b1001; dec.rw = 1'b1; end
            OpXor: begin dec.fs = 4'b1010; dec.rw = 1'b1; end
            OpNot: begin dec.fs = 4'b1011; dec.rw = 1'b1; end
            OpLsl: begin dec.fs = 4'b1110; dec.rw = 1'b1; end
            OpLsr: begin dec.fs = 4'b1101; dec.rw = 1'b1; end
            OpLd:  begin dec.rw = 1'b1; dec.md = MdMem; end
            OpSt:  dec.mw = 1'b1;
            OpAdi: begin dec.fs = 4'b0010; dec.rw = 1'b1; dec.mb = 1'b1; sext = 1'b1; end
            OpSbi: begin dec.fs = 4'b0101; dec.rw = 1'b1; dec.mb = 1'b1; sext = 1'b1; end
            OpAni: begin dec.fs = 4'b1000; dec.rw = 1'b1; dec.mb = 1'b1; zext = 1'b1; end
            OpOri: begin dec.fs = 4'b1001; dec.rw = 1'b1; dec.mb = 1'b1; zext = 1'b1; end
            OpXri: begin dec.fs = 4'b1010; dec.rw = 1'b1; dec.mb = 1'b1; zext = 1'b1; end
            OpAiu: begin dec.fs = 4'b0010; dec.rw = 1'b1; dec.mb = 1'b1; zext = 1'b1; end
            OpSiu: begin dec.fs = 4'b0101; dec.rw = 1'b1; dec.mb = 1'b1; zext = 1'b1; end
            OpBz:  begin dec.bs = BsZ; dec.ps = 1'b1; dec.mb = 1'b1; sext = 1'b1; end
            OpBnz: begin dec.bs = BsZ; dec.ps = 1'b0; dec.mb = 1'b1; sext = 1'b1; end
            OpJmr: dec.bs = BsJr;
            OpJmp: begin dec.bs = BsJi; dec.mb = 1'b1; sext = 1'b1; end
            OpJml: begin
                dec.fs = 4'b0111;
                dec.rw = 1'b1;
                dec.ma = 1'b1;
                dec.bs = BsJi;
                dec.mb = 1'b1;
                sext   = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (legal) begin
            dec.da = bus.instr[24:20];
            dec.sa = bus.instr[19:15];
            dec.sb = bus.instr[14:10];
            dec.sh = bus.instr[4:0];
            if (sext) begin
                dec.imm = imm_sext;
            end else if (zext) begin
                dec.imm = imm_zext;
            end
        end else begin
            // Unknown opcode becomes an all-zero NOP with only the flag raised.
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Load-use hazard: the held LD result is not available to the instruction right behind it.
    // SB only counts as a source when the B bus is not taking the immediate; R0 is hard-wired.
    assign held_ld = out_valid_q & ctrl_q.rw & (ctrl_q.md == MdMem);
    assign hazard  = held_ld & (ctrl_q.da != 5'd0) &
                     ((dec.sa == ctrl_q.da) | (!dec.mb & (dec.sb == ctrl_q.da)));
    // The bubble replaces the LD only when the LD is leaving this cycle.
    assign bubble  = rdy_en_q & bus.in_valid & bus.out_ready & hazard;

    assign in_ready = rdy_en_q & (!out_valid_q | bus.out_ready) & !bubble;
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            ctrl_d      = '0;
        end else if (bubble) begin
            out_valid_d = 1'b1;
            ctrl_d      = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            rdy_en_q    <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.fs        = ctrl_q.fs;
    assign bus.sh        = ctrl_q.sh;
    assign bus.da        = ctrl_q.da;
    assign bus.sa        = ctrl_q.sa;
    assign bus.sb        = ctrl_q.sb;
    assign bus.imm       = ctrl_q.imm;
    assign bus.ma        = ctrl_q.ma;
    assign bus.mb        = ctrl_q.mb;
    assign bus.rw        = ctrl_q.rw;
    assign bus.mw        = ctrl_q.mw;
    assign bus.md        = ctrl_q.md;
    assign bus.bs        = ctrl_q.bs;
    assign bus.ps        = ctrl_q.ps;
    assign bus.illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: stimulus pushes expected control words, a negedge
// monitor pops and compares every word EX consumes.
module tb_instr_decode;

    typedef struct packed {
        logic [3:0]  fs;
        logic [4:0]  sh;
        logic [4:0]  da;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [31:0] imm;
        logic        ma;
        logic        mb;
        logic        rw;
        logic        mw;
        logic [1:0]  md;
        logic [1:0]  bs;
        logic        ps;
        logic        illegal;
    } word_t;

    localparam logic [6:0] O_MOV = 7'b1000000;
    localparam logic [6:0] O_ADD = 7'b0000010;
    localparam logic [6:0] O_SUB = 7'b0000101;
    localparam logic [6:0] O_SLT = 7'b1100101;
    localparam logic [6:0] O_XOR = 7'b0001010;
    localparam logic [6:0] O_OR  = 7'b0001001;
    localparam logic [6:0] O_NOT = 7'b0101110;
    localparam logic [6:0] O_LSR = 7'b0110001;
    localparam logic [6:0] O_LD  = 7'b0100001;
    localparam logic [6:0] O_ST  = 7'b0000001;
    localparam logic [6:0] O_ADI = 7'b0100010;
    localparam logic [6:0] O_ANI = 7'b0101000;
    localparam logic [6:0] O_XRI = 7'b0101010;
    localparam logic [6:0] O_SIU = 7'b1000101;
    localparam logic [6:0] O_BZ  = 7'b0100000;
    localparam logic [6:0] O_BNZ = 7'b1100000;
    localparam logic [6:0] O_JMR = 7'b1100001;
    localparam logic [6:0] O_JMP = 7'b1000100;
    localparam logic [6:0] O_JML = 7'b0000111;
    localparam logic [6:0] O_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_decode_if bus ();

    instr_decode #(.IMM_W(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    word_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    word_t mon_exp;
    word_t mon_act;

    function automatic word_t actual();
        word_t w;
        w.fs = bus.fs; w.sh = bus.sh; w.da = bus.da; w.sa = bus.sa; w.sb = bus.sb;
        w.imm = bus.imm; w.ma = bus.ma; w.mb = bus.mb; w.rw = bus.rw; w.mw = bus.mw;
        w.md = bus.md; w.bs = bus.bs; w.ps = bus.ps; w.illegal = bus.illegal;
        return w;
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] op, logic [4:0] d, logic [4:0] s,
                                          logic [4:0] t);
        return {op, d, s, t, 10'd0};
    endfunction

    function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] d, logic [4:0] s,
                                          logic [14:0] im);
        return {op, d, s, im};
    endfunction

    // Expected word for a legal instruction: register/shift fields come from the layout.
    function automatic word_t ew(logic [31:0] ins, logic [3:0] fs, logic rw, logic mw,
                                 logic ma, logic mb, logic [1:0] md, logic [1:0] bs,
                                 logic ps, logic [31:0] imm);
        word_t w;
        w = '0;
        w.fs = fs; w.rw = rw; w.mw = mw; w.ma = ma; w.mb = mb; w.md = md; w.bs = bs;
        w.ps = ps; w.imm = imm;
        w.da = ins[24:20]; w.sa = ins[19:15]; w.sb = ins[14:10]; w.sh = ins[4:0];
        return w;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction until accepted; waits = cycles in_ready was low.
    task automatic offer(logic [31:0] ins, output int waits);
        logic acc;
        bus.instr    = ins;
        bus.in_valid = 1'b1;
        waits        = 0;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            if (acc) break;
            waits++;
            if (waits > 20) begin
                check("offer_timeout", 128'(waits), 128'(0));
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            mon_act = actual();
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got %h expected none", mon_act);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard: got %h expected %h", mon_act, mon_exp);
                end
            end
        end
    end

    logic [31:0] tv_i[14];
    word_t       tv_e[14];
    logic [31:0] i_ld;
    logic [31:0] i_use;
    logic [31:0] i_add;
    logic [31:0] i_sub;
    word_t       e_ld;
    word_t       e_add;
    int          w;

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_word", 128'(actual()), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
        tick();

        // ADD R3,R1,R2 with one-cycle latency
        i_add = enc_r(O_ADD, 5'd3, 5'd1, 5'd2);
        e_add = ew(i_add, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
        sb_q.push_back(e_add);
        offer(i_add, w);
        @(negedge clk);
        check("t1_out_valid", 128'(bus.out_valid), 128'(1));
        check("t1_fs_da_sa_sb", 128'({bus.fs, bus.da, bus.sa, bus.sb}),
              128'({4'b0010, 5'd3, 5'd1, 5'd2}));
        tick();

        // Opcode table, streamed with out_ready high
        tv_i[0] = enc_i(O_ADI, 5'd1, 5'd2, 15'h7FFF);
        tv_e[0] = ew(tv_i[0], 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFFF);
        tv_i[1] = enc_i(O_ANI, 5'd1, 5'd2, 15'h7FFF);
        tv_e[1] = ew(tv_i[1], 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0000_7FFF);
        tv_i[2] = enc_r(O_SLT, 5'd6, 5'd1, 5'd2);
        tv_e[2] = ew(tv_i[2], 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 32'h0);
        tv_i[3] = enc_r(O_ST, 5'd0, 5'd1, 5'd2);
        tv_e[3] = ew(tv_i[3], 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
        tv_i[4] = enc_i(O_BZ, 5'd0, 5'd1, 15'h4000);
        tv_e[4] = ew(tv_i[4], 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 32'hFFFF_C000);
        tv_i[5] = enc_i(O_BNZ, 5'd0, 5'd1, 15'h0005);
        tv_e[5] = ew(tv_i[5], 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 32'h0000_0005);
        tv_i[6] = enc_r(O_JMR, 5'd0, 5'd7, 5'd0);
        tv_e[6] = ew(tv_i[6], 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 32'h0);
        tv_i[7] = enc_i(O_JMP, 5'd0, 5'd0, 15'h7FFE);
        tv_e[7] = ew(tv_i[7], 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 1'b0, 32'hFFFF_FFFE);
        tv_i[8] = enc_i(O_JML, 5'd31, 5'd0, 15'h0010);
        tv_e[8] = ew(tv_i[8], 4'b0111, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 1'b0, 32'h0000_0010);
        tv_i[9] = enc_i(O_SIU, 5'd2, 5'd3, 15'h4001);
        tv_e[9] = ew(tv_i[9], 4'b0101, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0000_4001);
        tv_i[10] = enc_i(O_LSR, 5'd2, 5'd3, 15'h0007);
        tv_e[10] = ew(tv_i[10], 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
        tv_i[11] = enc_r(O_NOT, 5'd4, 5'd5, 5'd0);
        tv_e[11] = ew(tv_i[11], 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
        tv_i[12] = enc_i(O_XRI, 5'd1, 5'd2, 15'h4000);
        tv_e[12] = ew(tv_i[12], 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0000_4000);
        tv_i[13] = enc_r(O_BAD, 5'd1, 5'd2, 5'd3);
        tv_e[13] = '0;
        tv_e[13].illegal = 1'b1;
        for (int k = 0; k < 14; k++) begin
            sb_q.push_back(tv_e[k]);
            offer(tv_i[k], w);
            check("stream_no_stall", 128'(w), 128'(0));
        end
        tick();

        // Load-use: LD R4 followed by a consumer of R4 via SA, then via SA with mb=1
        i_ld = enc_r(O_LD, 5'd4, 5'd1, 5'd0);
        e_ld = ew(i_ld, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) i_use = enc_r(O_ADD, 5'd5, 5'd4, 5'd1);
            else        i_use = enc_i(O_ADI, 5'd5, 5'd4, 15'h1001);
            sb_q.push_back(e_ld);
            sb_q.push_back('0);
            if (k == 0)
                sb_q.push_back(ew(i_use, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0,
                                  32'h0));
            else
                sb_q.push_back(ew(i_use, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0,
                                  32'h0000_1001));
            offer(i_ld, w);
            offer(i_use, w);
            check("loaduse_one_bubble", 128'(w), 128'(1));
            @(negedge clk);
            check("loaduse_ready_back", 128'(bus.in_ready), 128'(1));
            tick();
        end

        // No bubble: SB matches DA but mb=1; DA=R0
        i_use = enc_i(O_ADI, 5'd5, 5'd1, 15'h1001);
        sb_q.push_back(e_ld);
        sb_q.push_back(ew(i_use, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0,
                          32'h0000_1001));
        offer(i_ld, w);
        offer(i_use, w);
        check("loaduse_sb_imm_no_bubble", 128'(w), 128'(0));
        i_ld  = enc_r(O_LD, 5'd0, 5'd1, 5'd0);
        i_use = enc_r(O_ADD, 5'd5, 5'd0, 5'd0);
        sb_q.push_back(ew(i_ld, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 32'h0));
        sb_q.push_back(ew(i_use, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0));
        offer(i_ld, w);
        offer(i_use, w);
        check("loaduse_r0_no_bubble", 128'(w), 128'(0));
        tick();

        // Stall: ADD held for 3 cycles while SUB is offered
        i_sub = enc_r(O_SUB, 5'd7, 5'd3, 5'd3);
        sb_q.push_back(e_add);
        sb_q.push_back(ew(i_sub, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0));
        bus.out_ready = 1'b0;
        offer(i_add, w);
        bus.instr    = i_sub;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_valid", 128'(bus.out_valid), 128'(1));
            check("stall_word", 128'(actual()), 128'(e_add));
            check("stall_in_ready", 128'(bus.in_ready), 128'(0));
            tick();
        end
        bus.out_ready = 1'b1;
        offer(i_sub, w);
        check("stall_resume", 128'(w), 128'(0));
        tick();

        // Flush with a held word and an offered instruction
        sb_q.push_back(e_add);
        bus.out_ready = 1'b0;
        offer(i_add, w);
        bus.instr    = enc_r(O_XOR, 5'd1, 5'd1, 5'd1);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        check("flush_held", 128'(bus.out_valid), 128'(0));
        tick();
        bus.out_ready = 1'b1;
        // Flush with an empty stage that would otherwise load
        bus.instr    = enc_r(O_OR, 5'd2, 5'd2, 5'd2);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_incoming", 128'(bus.out_valid), 128'(0));
        tick();
        // Flush drops a pending bubble
        i_ld = enc_r(O_LD, 5'd4, 5'd1, 5'd0);
        sb_q.push_back(ew(i_ld, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 32'h0));
        offer(i_ld, w);
        bus.instr    = enc_r(O_ADD, 5'd5, 5'd4, 5'd1);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_bubble", 128'(bus.out_valid), 128'(0));
        tick();

        // Reset during a stall
        sb_q.push_back(e_add);
        bus.out_ready = 1'b0;
        offer(i_add, w);
        bus.instr    = i_sub;
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        tick();
        void'(sb_q.pop_back());
        @(negedge clk);
        check("rst_stall_valid", 128'(bus.out_valid), 128'(0));
        check("rst_stall_word", 128'(actual()), 128'(0));
        check("rst_stall_in_ready", 128'(bus.in_ready), 128'(0));
        tick();
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        @(negedge clk);
        check("rst_stall_ready_back", 128'(bus.in_ready), 128'(1));
        check("rst_stall_no_replay", 128'(bus.out_valid), 128'(0));
        tick();
        bus.out_ready = 1'b1;

        for (int k = 0; k < 50 && sb_q.size() != 0; k++) tick();
        repeat (3) tick();
        check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
